clock_set_controller: RTL and testbench

Central sequencer for the alarm-clock datapath. It generates the one-cycle count pulses for the seconds, minutes and hours BCD counter chains and for the alarm minute/hour counters. It runs the time-set and alarm-set mode state machine from the user buttons. It also runs the alarm ring/snooze state machine. It sits between the debounced button inputs, the digit-counter bank and the display/buzzer drivers.

---
 rtl/clock_set_controller_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 24 ++
 rtl/clock_set_controller.sv | 162 ++++++++++++++++
 tb/tb_clock_set_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_controller_pkg.sv
// Shared encodings for the alarm-clock sequencer: set modes, ring states and
// the ring/snooze counter sizing helper.
package clock_set_controller_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN       = 3'd0,
    MODE_SET_T_HR  = 3'd1,
    MODE_SET_T_MIN = 3'd2,
    MODE_SET_A_HR  = 3'd3,
    MODE_SET_A_MIN = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    RS_IDLE    = 2'd0,
    RS_RINGING = 2'd1,
    RS_SNOOZED = 2'd2
  } ring_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick when the count sits at TICK_DIV-1.
// Tick is combinational from the count register; no backpressure.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clk,
  input  logic Clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/clock_set_controller.sv
// Alarm-clock sequencer: counter pulses, set-mode FSM and ring/snooze FSM.
// Pulse outputs are registered (one cycle after the causing tick/button); no backpressure.
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Mode_btn,
  input  logic              Inc_btn,
  input  logic              Snooze_btn,
  input  logic              Alarm_On,
  input  logic              Sec_Wrap,
  input  logic              Min_Wrap,
  input  logic              Alarm_Match,
  output logic              Sec_Up,
  output logic              Min_Up,
  output logic              Hr_Up,
  output logic              AMin_Up,
  output logic              AHr_Up,
  output logic              Sec_Clr,
  output logic [MODE_W-1:0] Mode,
  output logic              Blink,
  output logic              Ringing
);

  localparam int CW = cnt_width(RING_SEC, SNOOZE_SEC);
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC - 1);

  logic          tick;
  mode_e         mode_q, mode_d;
  ring_e         ring_q, ring_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          am_q, live_q;
  logic          blink_q, blink_d;
  logic          sec_up_q, min_up_q, hr_up_q, amin_up_q, ahr_up_q, sec_clr_q;
  logic          sec_up_d, min_up_d, hr_up_d, amin_up_d, ahr_up_d, sec_clr_d;
  logic          keep_time, tk, inc, match_rise;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .Clk  (Clk),
    .Clr  (Clr),
    .tick (tick)
  );

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:       if (Mode_btn) mode_d = MODE_SET_T_HR;
      MODE_SET_T_HR:  if (Mode_btn) mode_d = MODE_SET_T_MIN;
      MODE_SET_T_MIN: if (Mode_btn) mode_d = MODE_SET_A_HR;
      MODE_SET_A_HR:  if (Mode_btn) mode_d = MODE_SET_A_MIN;
      MODE_SET_A_MIN: if (Mode_btn) mode_d = MODE_RUN;
      default:        mode_d = MODE_RUN;
    endcase
  end

  // live_q masks the reset-release cycle so nothing fires before history is valid.
  always_comb begin
    keep_time = (mode_q == MODE_RUN) || (mode_q == MODE_SET_A_HR) ||
                (mode_q == MODE_SET_A_MIN);
    tk        = tick & keep_time & live_q;
    inc       = Inc_btn & ~Mode_btn & live_q;
    sec_up_d  = tk;
    min_up_d  = (tk & Sec_Wrap) | (inc & (mode_q == MODE_SET_T_MIN));
    hr_up_d   = (tk & Sec_Wrap & Min_Wrap) | (inc & (mode_q == MODE_SET_T_HR));
    ahr_up_d  = inc & (mode_q == MODE_SET_A_HR);
    amin_up_d = inc & (mode_q == MODE_SET_A_MIN);
    sec_clr_d = ~(Mode_btn & (mode_q == MODE_SET_T_MIN));
    blink_d   = blink_q;
    if (mode_d == MODE_RUN) blink_d = 1'b0;
    else if (tick)          blink_d = ~blink_q;
  end

  always_comb begin
    ring_d     = ring_q;
    rcnt_d     = rcnt_q;
    match_rise = Alarm_Match & ~am_q & live_q;
    case (ring_q)
      RS_IDLE: begin
        if (match_rise && Alarm_On && (mode_q == MODE_RUN)) begin
          ring_d = RS_RINGING;
          rcnt_d = RING_LOAD;
        end
      end
      RS_RINGING: begin
        if (!Alarm_On) begin
          ring_d = RS_IDLE;
          rcnt_d = '0;
        end else if (Snooze_btn) begin
          ring_d = RS_SNOOZED;
          rcnt_d = SNOOZE_LOAD;
        end else if (tick) begin
          if (rcnt_q == '0) ring_d = RS_IDLE;
          else              rcnt_d = rcnt_q - CW'(1);
        end
      end
      RS_SNOOZED: begin
        if (!Alarm_On) begin
          ring_d = RS_IDLE;
          rcnt_d = '0;
        end else if (tick) begin
          if (rcnt_q == '0) begin
            ring_d = RS_RINGING;
            rcnt_d = RING_LOAD;
          end else begin
            rcnt_d = rcnt_q - CW'(1);
          end
        end
      end
      default: begin
        ring_d = RS_IDLE;
        rcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mode_q    <= MODE_RUN;
      ring_q    <= RS_IDLE;
      rcnt_q    <= '0;
      am_q      <= 1'b0;
      live_q    <= 1'b0;
      blink_q   <= 1'b0;
      sec_up_q  <= 1'b0;
      min_up_q  <= 1'b0;
      hr_up_q   <= 1'b0;
      amin_up_q <= 1'b0;
      ahr_up_q  <= 1'b0;
      sec_clr_q <= 1'b1;
    end else begin
      mode_q    <= mode_d;
      ring_q    <= ring_d;
      rcnt_q    <= rcnt_d;
      am_q      <= Alarm_Match;
      live_q    <= 1'b1;
      blink_q   <= blink_d;
      sec_up_q  <= sec_up_d;
      min_up_q  <= min_up_d;
      hr_up_q   <= hr_up_d;
      amin_up_q <= amin_up_d;
      ahr_up_q  <= ahr_up_d;
      sec_clr_q <= sec_clr_d;
    end
  end

  assign Sec_Up  = sec_up_q;
  assign Min_Up  = min_up_q;
  assign Hr_Up   = hr_up_q;
  assign AMin_Up = amin_up_q;
  assign AHr_Up  = ahr_up_q;
  assign Sec_Clr = sec_clr_q;
  assign Mode    = mode_q;
  assign Blink   = blink_q;
  assign Ringing = (ring_q == RS_RINGING);

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2.
module tb_clock_set_controller;

  logic       Clk = 1'b0;
  logic       Clr, Mode_btn, Inc_btn, Snooze_btn, Alarm_On, Sec_Wrap, Min_Wrap, Alarm_Match;
  logic       Sec_Up, Min_Up, Hr_Up, AMin_Up, AHr_Up, Sec_Clr, Blink, Ringing;
  logic [2:0] Mode;
  int         errors = 0;
  int         checks = 0;
  int         tb_edges;

  clock_set_controller #(.TICK_DIV(4), .RING_SEC(3), .SNOOZE_SEC(2)) dut (
    .Clk(Clk), .Clr(Clr), .Mode_btn(Mode_btn), .Inc_btn(Inc_btn),
    .Snooze_btn(Snooze_btn), .Alarm_On(Alarm_On), .Sec_Wrap(Sec_Wrap),
    .Min_Wrap(Min_Wrap), .Alarm_Match(Alarm_Match), .Sec_Up(Sec_Up),
    .Min_Up(Min_Up), .Hr_Up(Hr_Up), .AMin_Up(AMin_Up), .AHr_Up(AHr_Up),
    .Sec_Clr(Sec_Clr), .Mode(Mode), .Blink(Blink), .Ringing(Ringing)
  );

  always #5 Clk = ~Clk;

  // Reference phase: a tick is registered on every posedge whose index is a multiple of 4.
  always @(posedge Clk or negedge Clr)
    if (!Clr) tb_edges <= 0;
    else      tb_edges <= tb_edges + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic align_to_tick();
    while (((tb_edges + 1) % 4) != 0) @(negedge Clk);
  endtask

  task automatic press_mode();
    Mode_btn = 1'b1;
    @(negedge Clk);
    Mode_btn = 1'b0;
  endtask

  task automatic pulse_inc();
    Inc_btn = 1'b1;
    @(negedge Clk);
    Inc_btn = 1'b0;
  endtask

  task automatic test_reset();
    Clr = 1'b0; Mode_btn = 0; Inc_btn = 0; Snooze_btn = 0; Alarm_On = 0;
    Sec_Wrap = 0; Min_Wrap = 0; Alarm_Match = 0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Sec_Up, Min_Up, Hr_Up, AMin_Up, AHr_Up} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000", {Sec_Up, Min_Up, Hr_Up, AMin_Up, AHr_Up});
    end
    checks++;
    if ({Sec_Clr, Blink, Ringing, Mode} !== 6'b100000) begin
      errors++; $display("FAIL reset_state: got Sec_Clr/Blink/Ringing/Mode=%b expected 100000", {Sec_Clr, Blink, Ringing, Mode});
    end
    Clr = 1'b1;
  endtask

  task automatic test_tick_run();
    logic exp;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      exp = (i % 4 == 0);
      checks++;
      if (Sec_Up !== exp) begin
        errors++; $display("FAIL tick_sec_up cycle %0d: got %b expected %b", i, Sec_Up, exp);
      end
      checks++;
      if ({Min_Up, Hr_Up} !== 2'b00) begin
        errors++; $display("FAIL tick_no_carry cycle %0d: got %b expected 00", i, {Min_Up, Hr_Up});
      end
    end
  endtask

  task automatic test_wrap();
    align_to_tick();
    Sec_Wrap = 1; Min_Wrap = 1;
    @(negedge Clk);
    Sec_Wrap = 0; Min_Wrap = 0;
    checks++;
    if ({Sec_Up, Min_Up, Hr_Up} !== 3'b111) begin
      errors++; $display("FAIL wrap_all: got %b expected 111", {Sec_Up, Min_Up, Hr_Up});
    end
    @(negedge Clk);
    checks++;
    if ({Sec_Up, Min_Up, Hr_Up} !== 3'b000) begin
      errors++; $display("FAIL wrap_single_cycle: got %b expected 000", {Sec_Up, Min_Up, Hr_Up});
    end
    align_to_tick();
    Sec_Wrap = 1;
    @(negedge Clk);
    Sec_Wrap = 0;
    checks++;
    if ({Sec_Up, Min_Up, Hr_Up} !== 3'b110) begin
      errors++; $display("FAIL wrap_sec_only: got %b expected 110", {Sec_Up, Min_Up, Hr_Up});
    end
  endtask

  task automatic test_mode_walk();
    logic seen_sec, seen_blink;
    seen_sec = 0; seen_blink = 0;
    press_mode();
    checks++;
    if (Mode !== 3'd1) begin errors++; $display("FAIL mode_step1: got %0d expected 1", Mode); end
    repeat (8) begin
      @(negedge Clk);
      if (Sec_Up) seen_sec = 1;
      if (Blink) seen_blink = 1;
    end
    press_mode();
    checks++;
    if ({Mode, Sec_Clr} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL mode_step2: got Mode=%0d Sec_Clr=%b expected 2/1", Mode, Sec_Clr);
    end
    repeat (8) begin
      @(negedge Clk);
      if (Sec_Up) seen_sec = 1;
    end
    checks++;
    if (seen_sec !== 1'b0) begin errors++; $display("FAIL paused_sec_up: got %b expected 0", seen_sec); end
    checks++;
    if (seen_blink !== 1'b1) begin errors++; $display("FAIL blink_toggle: got %b expected 1", seen_blink); end
    press_mode();
    checks++;
    if ({Mode, Sec_Clr} !== {3'd3, 1'b0}) begin
      errors++; $display("FAIL mode_step3_clr: got Mode=%0d Sec_Clr=%b expected 3/0", Mode, Sec_Clr);
    end
    @(negedge Clk);
    checks++;
    if (Sec_Clr !== 1'b1) begin errors++; $display("FAIL sec_clr_one_cycle: got %b expected 1", Sec_Clr); end
    press_mode();
    checks++;
    if (Mode !== 3'd4) begin errors++; $display("FAIL mode_step4: got %0d expected 4", Mode); end
    press_mode();
    checks++;
    if ({Mode, Blink} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL mode_step0: got Mode=%0d Blink=%b expected 0/0", Mode, Blink);
    end
  endtask

  task automatic test_edit();
    press_mode(); press_mode();
    Min_Wrap = 1;
    pulse_inc();
    Min_Wrap = 0;
    checks++;
    if ({Min_Up, Hr_Up} !== 2'b10) begin
      errors++; $display("FAIL edit_min_no_carry: got %b expected 10", {Min_Up, Hr_Up});
    end
    Inc_btn = 1; Mode_btn = 1;
    @(negedge Clk);
    Inc_btn = 0; Mode_btn = 0;
    checks++;
    if ({Mode, Min_Up, Sec_Clr} !== {3'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL edit_mode_wins: got Mode=%0d Min_Up=%b Sec_Clr=%b expected 3/0/0", Mode, Min_Up, Sec_Clr);
    end
    pulse_inc();
    checks++;
    if ({AHr_Up, AMin_Up} !== 2'b10) begin
      errors++; $display("FAIL edit_alarm_hr: got %b expected 10", {AHr_Up, AMin_Up});
    end
    press_mode();
    pulse_inc();
    checks++;
    if ({AHr_Up, AMin_Up} !== 2'b01) begin
      errors++; $display("FAIL edit_alarm_min: got %b expected 01", {AHr_Up, AMin_Up});
    end
    press_mode();
    pulse_inc();
    checks++;
    if ({Min_Up, Hr_Up, AMin_Up, AHr_Up} !== 4'b0) begin
      errors++; $display("FAIL edit_run_ignored: got %b expected 0000", {Min_Up, Hr_Up, AMin_Up, AHr_Up});
    end
    press_mode();
    pulse_inc();
    checks++;
    if ({Hr_Up, Min_Up} !== 2'b10) begin
      errors++; $display("FAIL edit_time_hr: got %b expected 10", {Hr_Up, Min_Up});
    end
    repeat (4) press_mode();
    checks++;
    if (Mode !== 3'd0) begin errors++; $display("FAIL edit_back_to_run: got %0d expected 0", Mode); end
  endtask

  task automatic test_ring_timeout();
    logic exp;
    Alarm_On = 1;
    align_to_tick();
    Alarm_Match = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge Clk);
      exp = (i <= 12);
      checks++;
      if (Ringing !== exp) begin
        errors++; $display("FAIL ring_timeout cycle %0d: got %b expected %b", i, Ringing, exp);
      end
    end
    Alarm_Match = 0;
    @(negedge Clk);
  endtask

  task automatic test_snooze();
    logic exp, seen;
    align_to_tick();
    Alarm_Match = 1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clk);
      exp = (i <= 4) || (i >= 13);
      checks++;
      if (Ringing !== exp) begin
        errors++; $display("FAIL snooze cycle %0d: got %b expected %b", i, Ringing, exp);
      end
      Snooze_btn = (i == 4);
    end
    Snooze_btn = 1;
    @(negedge Clk);
    Snooze_btn = 0;
    checks++;
    if (Ringing !== 1'b0) begin errors++; $display("FAIL snooze_again: got %b expected 0", Ringing); end
    Alarm_On = 0;
    seen = 0;
    repeat (16) begin @(negedge Clk); if (Ringing) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL alarm_off_snoozed: got %b expected 0", seen); end
    Alarm_On = 1;
    repeat (8) begin @(negedge Clk); if (Ringing) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL no_edge_no_ring: got %b expected 0", seen); end
    Alarm_Match = 0;
    @(negedge Clk);
  endtask

  task automatic test_async_clr();
    logic seen;
    Alarm_Match = 1;
    @(negedge Clk);
    checks++;
    if (Ringing !== 1'b1) begin errors++; $display("FAIL clr_ring_start: got %b expected 1", Ringing); end
    repeat (3) press_mode();
    checks++;
    if ({Mode, Ringing} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL clr_setup: got Mode=%0d Ringing=%b expected 3/1", Mode, Ringing);
    end
    #2 Clr = 1'b0;
    #1;
    checks++;
    if ({Ringing, Mode, Blink, Sec_Clr} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL clr_async_state: got Ringing=%b Mode=%0d Blink=%b Sec_Clr=%b expected 0/0/0/1", Ringing, Mode, Blink, Sec_Clr);
    end
    checks++;
    if ({Sec_Up, Min_Up, Hr_Up, AMin_Up, AHr_Up} !== 5'b0) begin
      errors++; $display("FAIL clr_async_pulses: got %b expected 00000", {Sec_Up, Min_Up, Hr_Up, AMin_Up, AHr_Up});
    end
    @(negedge Clk);
    Clr = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge Clk); if (Ringing) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL clr_no_rering: got %b expected 0", seen); end
    Alarm_Match = 0;
  endtask

  initial begin
    test_reset();
    test_tick_run();
    test_wrap();
    test_mode_walk();
    test_edit();
    test_ring_timeout();
    test_snooze();
    test_async_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
